// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control: resolves stage stall requests into stall/bubble vectors, accepts
// exceptions/ERET from commit, and drives a flush plus a held, handshaked PC redirect.
module pipeline_hazard_ctrl #(
    parameter int                 STAGES  = 6,
    parameter int                 ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]  INIT_PC = 32'hbfc00000,
    parameter logic [ADDR_W-1:0]  EXC_PC  = 32'hbfc00380,
    parameter int                 TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stall_req,
    input  logic              stall_all,
    input  logic              exc_valid,
    input  logic              exc_eret,
    input  logic [ADDR_W-1:0] cp0_epc,
    input  logic              redirect_ready,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble,
    output logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              stall_timeout
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

    logic              redirect_valid_q, redirect_valid_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic              stall_timeout_q, stall_timeout_d;

    logic [STAGES-1:0] stall_v;
    logic              accept;
    logic              hi_seen;

    // A stall at stage k must also hold every younger stage below it.
    always_comb begin
        stall_v = '0;
        hi_seen = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            hi_seen    = hi_seen | stall_req[i];
            stall_v[i] = hi_seen;
        end
        if (stall_all) begin
            stall_v = '1;
        end
        if (redirect_valid_q && !redirect_ready) begin
            stall_v[0] = 1'b1;
        end
        if (rst) begin
            stall_v = '0;
        end
    end

    always_comb begin
        bubble    = '0;
        for (int i = 1; i < STAGES; i++) begin
            bubble[i] = stall_v[i-1] & ~stall_v[i];
        end
    end

    assign stall  = stall_v;
    assign accept = exc_valid & ~stall_all & ~rst;
    assign flush  = accept;

    // A new accept always wins over a handshake in the same cycle.
    always_comb begin
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        if (accept) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = exc_eret ? cp0_epc : EXC_PC;
        end else if (redirect_valid_q && redirect_ready) begin
            redirect_valid_d = 1'b0;
        end
    end

    always_comb begin
        wd_cnt_d = '0;
        if (stall_v[0]) begin
            wd_cnt_d = (wd_cnt_q == TMO_CNT) ? wd_cnt_q : wd_cnt_q + CNT_W'(1);
        end
        stall_timeout_d = (wd_cnt_d == TMO_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= INIT_PC;
            wd_cnt_q         <= '0;
            stall_timeout_q  <= 1'b0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            wd_cnt_q         <= wd_cnt_d;
            stall_timeout_q  <= stall_timeout_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign stall_timeout  = stall_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios followed by random traffic, all compared
// against a behavioural model of the stall, redirect and watchdog rules.
module tb_pipeline_hazard_ctrl;

    localparam int          STAGES  = 6;
    localparam int          ADDR_W  = 32;
    localparam logic [31:0] INIT_PC = 32'hbfc00000;
    localparam logic [31:0] EXC_PC  = 32'hbfc00380;
    localparam int          TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [STAGES-1:0] stall_req;
    logic              stall_all;
    logic              exc_valid;
    logic              exc_eret;
    logic [ADDR_W-1:0] cp0_epc;
    logic              redirect_ready;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] bubble;
    logic              flush;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              stall_timeout;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit          m_rv;
    logic [31:0] m_pc;
    int          m_cnt;
    bit          m_to;

    pipeline_hazard_ctrl #(
        .STAGES(STAGES), .ADDR_W(ADDR_W), .INIT_PC(INIT_PC),
        .EXC_PC(EXC_PC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req), .stall_all(stall_all),
        .exc_valid(exc_valid), .exc_eret(exc_eret), .cp0_epc(cp0_epc),
        .redirect_ready(redirect_ready), .stall(stall), .bubble(bubble),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [STAGES-1:0] model_stall();
        logic [STAGES-1:0] s;
        int k;
        s = '0;
        if (rst) return s;
        k = -1;
        for (int i = 0; i < STAGES; i++) if (stall_req[i]) k = i;
        for (int j = 0; j <= k; j++) s[j] = 1'b1;
        if (stall_all) s = '1;
        if (m_rv && !redirect_ready) s[0] = 1'b1;
        return s;
    endfunction

    function automatic logic [STAGES-1:0] model_bubble(input logic [STAGES-1:0] s);
        logic [STAGES-1:0] b;
        b = '0;
        for (int i = 1; i < STAGES; i++) if (s[i-1] && !s[i]) b[i] = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        m_rv  = 1'b1;
        m_pc  = INIT_PC;
        m_cnt = 0;
        m_to  = 1'b0;
    endtask

    // Drive one cycle of inputs, check all outputs, clock, then advance the model.
    task automatic cyc(input bit r, input logic [STAGES-1:0] req, input bit sa,
                       input bit ev, input bit ee, input logic [31:0] epc, input bit rdy);
        logic [STAGES-1:0] s;
        bit acc;
        rst = r; stall_req = req; stall_all = sa; exc_valid = ev;
        exc_eret = ee; cp0_epc = epc; redirect_ready = rdy;
        if (r) model_reset();
        #1;
        s   = model_stall();
        acc = ev && !sa && !r;
        check("stall",          64'(stall),          64'(s));
        check("bubble",         64'(bubble),         64'(model_bubble(s)));
        check("flush",          64'(flush),          64'(acc));
        check("redirect_valid", 64'(redirect_valid), 64'(m_rv));
        check("redirect_pc",    64'(redirect_pc),    64'(m_pc));
        check("stall_timeout",  64'(stall_timeout),  64'(m_to));
        @(posedge clk);
        if (!r) begin
            if (acc) begin
                m_rv = 1'b1;
                m_pc = ee ? epc : EXC_PC;
            end else if (m_rv && rdy) begin
                m_rv = 1'b0;
            end
            m_cnt = s[0] ? ((m_cnt + 1 > TIMEOUT) ? TIMEOUT : m_cnt + 1) : 0;
            m_to  = (m_cnt == TIMEOUT);
        end
        #1;
    endtask

    logic [STAGES-1:0] rq;

    initial begin
        rst = 1'b1; stall_req = '0; stall_all = 0; exc_valid = 0;
        exc_eret = 0; cp0_epc = '0; redirect_ready = 0;
        model_reset();
        @(posedge clk); #1;
        cyc(1, 6'b111111, 1, 1, 0, 0, 0);      // outputs gated in reset
        check("rst_stall_gated", 64'(stall), 64'(0));

        // boot redirect: ready low 3 cycles then handshake
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        check("boot_pc", 64'(redirect_pc), 64'(32'hbfc00000));
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("boot_released", 64'(redirect_valid), 64'(0));

        // stall resolution
        cyc(0, 6'b000100, 0, 0, 0, 0, 0);
        cyc(0, 6'b010100, 0, 0, 0, 0, 0);
        cyc(0, 6'b010100, 1, 0, 0, 0, 0);

        // exception then ERET
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("exc_vector", 64'(redirect_pc), 64'(32'hbfc00380));
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1, 32'h80001234, 0);
        check("eret_epc", 64'(redirect_pc), 64'(32'h80001234));
        cyc(0, 0, 0, 0, 0, 0, 1);

        // masked exception, then retry
        cyc(0, 0, 1, 1, 0, 0, 1);
        check("masked_no_redirect", 64'(redirect_valid), 64'(0));
        cyc(0, 0, 0, 1, 0, 0, 0);

        // exception on handshake cycle: latest wins
        cyc(0, 0, 0, 1, 1, 32'h80000010, 1);
        check("latest_wins_valid", 64'(redirect_valid), 64'(1));
        check("latest_wins_pc",    64'(redirect_pc),    64'(32'h80000010));
        cyc(0, 0, 0, 0, 0, 0, 1);

        // watchdog
        repeat (4) cyc(0, 6'b000001, 0, 0, 0, 0, 0);
        check("wd_rise", 64'(stall_timeout), 64'(1));
        cyc(0, 6'b000001, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("wd_fall", 64'(stall_timeout), 64'(0));

        // reset mid-redirect discards pending target
        cyc(0, 0, 0, 1, 1, 32'h12345678, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("rst_mid_redirect", 64'(redirect_pc), 64'(32'hbfc00000));

        // random traffic
        rq = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0)
                rq = ($urandom_range(0, 1) == 0) ? '0 : STAGES'($urandom);
            cyc($urandom_range(0, 299) == 0, rq,
                $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                1'($urandom), $urandom, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
